// File: rtl/mul_datapath_controller_pkg.sv
// Shared definitions for the shift-add multiplier and its divider sibling.
// Holds the controller state encoding and the default operand width.
package mul_datapath_controller_pkg;

    localparam int unsigned MUL_WIDTH = 16;

    // Encoding is shared with the divider controller; keep values fixed.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_B = 2'd1,
        S_CALC   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/mul_datapath_controller_datapath.sv
// Datapath of the shift-add multiplier: A, P_hi, P_lo, count, adder/shifter.
// Ports: LoadA_i/LoadB_i/Clear_i/AddShift_i strobes, Data_in_i operand bus,
//        CountDone_o/Zero_o status, Prod_o = {P_hi,P_lo}.
module mul_datapath
    import mul_datapath_controller_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               LoadA_i,
    input  logic               LoadB_i,
    input  logic               Clear_i,
    input  logic               AddShift_i,
    input  logic [WIDTH-1:0]   Data_in_i,
    output logic               CountDone_o,
    output logic               Zero_o,
    output logic [2*WIDTH-1:0] Prod_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] phi_q, phi_d;
    logic [WIDTH-1:0] plo_q, plo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // {carry, P_hi} after the conditional add; carry lives in sum[WIDTH]
    logic [WIDTH:0]   sum;

    always_comb begin
        sum   = {1'b0, phi_q} + (plo_q[0] ? {1'b0, a_q} : '0);
        a_d   = a_q;
        phi_d = phi_q;
        plo_d = plo_q;
        cnt_d = cnt_q;
        if (LoadA_i) begin
            a_d = Data_in_i;
        end
        if (Clear_i) begin
            phi_d = '0;
            cnt_d = '0;
        end
        if (LoadB_i) begin
            // A==0 short-cut must leave {P_hi,P_lo}==0 for the product
            plo_d = (a_q == '0) ? '0 : Data_in_i;
        end
        if (AddShift_i) begin
            // shift {carry,P_hi,P_lo} right by one; carry lands in P_hi MSB
            phi_d = sum[WIDTH:1];
            plo_d = {sum[0], plo_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            phi_q <= '0;
            plo_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
            cnt_q <= cnt_d;
        end
    end

    assign CountDone_o = (cnt_q == CW'(WIDTH - 1));
    assign Zero_o      = (a_q == '0) || (Data_in_i == '0);
    assign Prod_o      = {phi_q, plo_q};

endmodule

// File: rtl/mul_datapath_controller.sv
// Sequential shift-add unsigned multiplier: FSM control path + mul_datapath.
// Ports: clk, rst_n, Start, Data_in (A then B), Product, Busy, Stop.
module mul_datapath_controller
    import mul_datapath_controller_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Start,
    input  logic [WIDTH-1:0]   Data_in,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy,
    output logic               Stop
);

    state_e               state_q;
    logic                 busy_q;
    logic                 stop_q;
    logic [2*WIDTH-1:0]   prod_q;

    logic                 load_a;
    logic                 load_b;
    logic                 add_shift;
    logic                 count_done;
    logic                 zero;
    logic [2*WIDTH-1:0]   dp_prod;

    assign load_a    = (state_q == S_IDLE) && Start;
    assign load_b    = (state_q == S_LOAD_B);
    assign add_shift = (state_q == S_CALC);

    mul_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .LoadA_i    (load_a),
        .LoadB_i    (load_b),
        .Clear_i    (load_b),
        .AddShift_i (add_shift),
        .Data_in_i  (Data_in),
        .CountDone_o(count_done),
        .Zero_o     (zero),
        .Prod_o     (dp_prod)
    );

    // Outputs are registered from the current state, so they trail the
    // state by one clock: Stop rises WIDTH+2 edges after Start is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            stop_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            busy_q <= (state_q == S_LOAD_B) || (state_q == S_CALC);
            stop_q <= (state_q == S_DONE);
            if (state_q == S_LOAD_B) begin
                prod_q <= '0;
            end else if (state_q == S_DONE) begin
                prod_q <= dp_prod;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (Start) state_q <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    state_q <= zero ? S_DONE : S_CALC;
                end
                S_CALC: begin
                    if (count_done) state_q <= S_DONE;
                end
                S_DONE: begin
                    // four-phase: wait for Start to drop before re-arming
                    if (!Start) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Product = prod_q;
    assign Busy    = busy_q;
    assign Stop    = stop_q;

endmodule
